// File: rtl/drum_hit_in_pio.sv
// Drum-pad hit input PIO: per-channel two-flop synchroniser, programmable
// debounce, rising-edge capture with write-one-to-clear, and a maskable
// level interrupt. Zero-wait-state register reads.
module drum_hit_in_pio #(
    parameter int WIDTH       = 6,
    parameter int DEB_W       = 16,
    parameter int DEB_DEFAULT = 5000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_THRESH  = 2'd1;
    localparam logic [1:0] ADDR_MASK    = 2'd2;
    localparam logic [1:0] ADDR_CAPTURE = 2'd3;

    logic [WIDTH-1:0] sync_p0;
    logic [WIDTH-1:0] sync_p1;
    logic [WIDTH-1:0] deb;
    logic [DEB_W-1:0] cnt [WIDTH];
    logic [DEB_W-1:0] thresh;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] capture;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] clr;
    logic             wr;
    logic             unused_wdata;

    assign wr           = chipselect && !write_n;
    assign unused_wdata = ^writedata[31:DEB_W];

    // Two-flop synchroniser for the asynchronous pad lines
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= in_port;
            sync_p1 <= sync_p0;
        end
    end

    // Debounce: a level change is accepted after THRESH+1 consecutive mismatch cycles
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            deb <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync_p1[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == thresh) begin
                    deb[i] <= sync_p1[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // Accept events that take deb from 0 to 1, and the W1C clear mask of this cycle
    always_comb begin
        rise = '0;
        for (int i = 0; i < WIDTH; i++) begin
            rise[i] = sync_p1[i] && !deb[i] && (cnt[i] == thresh);
        end
        clr = (wr && address == ADDR_CAPTURE) ? writedata[WIDTH-1:0] : '0;
    end

    // Software-programmable threshold and interrupt mask
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            thresh <= DEB_W'(DEB_DEFAULT);
            mask   <= '0;
        end else if (wr) begin
            if (address == ADDR_THRESH) begin
                thresh <= writedata[DEB_W-1:0];
            end
            if (address == ADDR_MASK) begin
                mask <= writedata[WIDTH-1:0];
            end
        end
    end

    // Capture register: a new rising edge wins over a same-cycle clear of that bit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            capture <= '0;
        end else begin
            capture <= (capture & ~clr) | rise;
        end
    end

    // Combinational read mux, no read side effects
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:    readdata[WIDTH-1:0] = deb;
            ADDR_THRESH:  readdata[DEB_W-1:0] = thresh;
            ADDR_MASK:    readdata[WIDTH-1:0] = mask;
            ADDR_CAPTURE: readdata[WIDTH-1:0] = capture;
            default:      readdata = '0;
        endcase
    end

    assign irq = |(capture & mask);

endmodule
